// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the round-robin multiplexing arbiter (mux_rr_arb):
//   MUX_N        default data width per channel (bits)
//   MUX_M        default number of input channels
//   mux_state_t  output-stage state: EMPTY (no data held) / FULL (data held)
//   wrap_inc()   (idx + 1) mod m, used to advance the round-robin pointer
// -----------------------------------------------------------------------------
package mux_pkg;

   localparam int unsigned MUX_N = 32;
   localparam int unsigned MUX_M = 4;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } mux_state_t;

   // Increment modulo m without a divider: idx is always < m here.
   function automatic int unsigned wrap_inc(input int unsigned idx,
                                            input int unsigned m);
      return (idx + 1 >= m) ? 0 : idx + 1;
   endfunction

endpackage : mux_pkg

// File: rtl/mux_rr_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Starting at position ptr and
// wrapping from M-1 to 0, the first asserted request wins.
// Ports:
//   req      [M]      request vector
//   ptr      [IW]     search start position (0..M-1)
//   gnt      [M]      one-hot grant, all zero when no request
//   gnt_idx  [IW]     binary index of the granted request (0 when none)
//   gnt_any  [1]      at least one request was granted
// -----------------------------------------------------------------------------
module rr_pick
   import mux_pkg::*;
#(
   parameter int unsigned M = MUX_M
) (
   input  logic [M-1:0]         req,
   input  logic [$clog2(M)-1:0] ptr,
   output logic [M-1:0]         gnt,
   output logic [$clog2(M)-1:0] gnt_idx,
   output logic                 gnt_any
);

   localparam int unsigned IW = $clog2(M);

   // Position ptr + k folded back into 0..M-1 (both operands are < M).
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                              input int unsigned   k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= M) s = s - M;
      return IW'(s);
   endfunction

   always_comb begin
      // NOTE: every output gets a default before the loop; a path that leaves
      // one unassigned would infer a latch.
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int unsigned k = 0; k < M; k++) begin
         if (!gnt_any && req[wrap_add(ptr, k)]) begin
            gnt_any                = 1'b1;
            gnt_idx                = wrap_add(ptr, k);
            gnt[wrap_add(ptr, k)]  = 1'b1;
         end
      end
   end

endmodule : rr_pick

// File: rtl/mux_rr_arb.sv
// -----------------------------------------------------------------------------
// mux_rr_arb
// M-input round-robin arbiter feeding a single registered output stage.
// One channel is accepted per cycle when the output register is empty or
// being drained; its data and index load into the output register.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   enable     block enable; 0 freezes state and masks all outputs to 0
//   in_valid   [M]    per-channel request
//   in_data    [M*N]  flattened channel data, channel i at [i*N +: N]
//   in_ready   [M]    per-channel accept, one-hot or zero
//   out_valid         output register holds valid data
//   out_data   [N]    registered selected data
//   out_ready         downstream accepts out_data
//   out_idx    [IW]   channel index of out_data
//   lock              (only with MUX_RR_ARB_LOCK_EN) restrict grants to the
//                     last granted channel and keep the pointer still
//
// Configuration macro: MUX_RR_ARB_LOCK_EN adds the lock input.
// Legal M range is 2..16.
// -----------------------------------------------------------------------------
module mux_rr_arb
   import mux_pkg::*;
#(
   parameter int unsigned N = MUX_N,
   parameter int unsigned M = MUX_M
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
`ifdef MUX_RR_ARB_LOCK_EN
   input  logic                 lock,
`endif
   input  logic [M-1:0]         in_valid,
   input  logic [M*N-1:0]       in_data,
   output logic [M-1:0]         in_ready,
   output logic                 out_valid,
   output logic [N-1:0]         out_data,
   input  logic                 out_ready,
   output logic [$clog2(M)-1:0] out_idx
);

   localparam int unsigned IW = $clog2(M);

   // Registered state and its next-state values.
   mux_state_t    state_q, state_d;
   logic [IW-1:0] ptr_q,   ptr_d;
   logic [N-1:0]  data_q,  data_d;
   logic [IW-1:0] idx_q,   idx_d;

   // Arbitration signals.
   logic [M-1:0]  eligible;
   logic [M-1:0]  gnt;
   logic [IW-1:0] gnt_idx;
   logic          gnt_any;
   logic          accept;
   logic          hold_ptr;
   logic [N-1:0]  sel_data;

   // ---------------------------------------------------------------------------
   // Request eligibility. Under lock only the previously granted channel
   // (ptr - 1 mod M) may win, and the pointer is not advanced so the same
   // channel stays eligible on the following cycles.
   // ---------------------------------------------------------------------------
`ifdef MUX_RR_ARB_LOCK_EN
   logic [IW-1:0] last_idx;

   always_comb begin
      last_idx = (ptr_q == '0) ? IW'(M - 1) : ptr_q - 1'b1;
      hold_ptr = lock;
      eligible = lock ? (in_valid & (M'(1) << last_idx)) : in_valid;
   end
`else
   always_comb begin
      hold_ptr = 1'b0;
      eligible = in_valid;
   end
`endif

   rr_pick #(
      .M (M)
   ) u_pick (
      .req     (eligible),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // An accept needs the block enabled, a winning request, and room in the
   // output register (empty, or being drained this same cycle). Reset blocks
   // any accept so no in_ready is raised while rst is high.
   assign accept   = enable && !rst && gnt_any &&
                     ((state_q == EMPTY) || out_ready);
   assign in_ready = accept ? gnt : '0;

   // Data mux driven by the one-hot grant: AND-OR avoids a wide indexed
   // select and depends on in_data only through the data path.
   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < M; i++) begin
         sel_data = sel_data | (in_data[i*N +: N] & {N{gnt[i]}});
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic. With enable low nothing changes, including the drain
   // path, so the held entry survives a disabled period untouched.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      idx_d   = idx_q;
      if (accept) begin
         state_d = FULL;
         data_d  = sel_data;
         idx_d   = gnt_idx;
         if (!hold_ptr) begin
            ptr_d = IW'(wrap_inc(32'(gnt_idx), M));
         end
      end else if (enable && (state_q == FULL) && out_ready) begin
         state_d = EMPTY;
      end
   end

   // Output-stage FSM and its registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this edge.
      if (rst) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         data_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
      end
   end

   // Outputs are the registers gated by enable.
   assign out_valid = enable && (state_q == FULL);
   assign out_data  = enable ? data_q : '0;
   assign out_idx   = enable ? idx_q  : '0;

endmodule : mux_rr_arb

// File: tb/tb_mux_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arb
// Directed self-checking bench for mux_rr_arb with N=32, M=4. Inputs change
// 1 ns after a rising edge; outputs are sampled on the falling edge.
// The lock sequence is included when MUX_RR_ARB_LOCK_EN is defined.
// -----------------------------------------------------------------------------
module tb_mux_rr_arb;

   localparam int unsigned N = 32;
   localparam int unsigned M = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             enable;
   logic [M-1:0]     in_valid;
   logic [M*N-1:0]   in_data;
   logic [M-1:0]     in_ready;
   logic             out_valid;
   logic [N-1:0]     out_data;
   logic             out_ready;
   logic [1:0]       out_idx;
`ifdef MUX_RR_ARB_LOCK_EN
   logic             lock;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mux_rr_arb #(
      .N (N),
      .M (M)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
`ifdef MUX_RR_ARB_LOCK_EN
      .lock      (lock),
`endif
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_idx   (out_idx)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge (input drive point).
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Move to the falling edge (output sample point).
   task automatic samp();
      @(negedge clk);
   endtask

   task automatic set_data(input int ch, input logic [31:0] val);
      in_data[ch*N +: N] = val;
   endtask

   initial begin
      rst       = 1'b1;
      enable    = 1'b1;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      in_data   = '0;
`ifdef MUX_RR_ARB_LOCK_EN
      lock      = 1'b0;
`endif
      for (int i = 0; i < 4; i++) set_data(i, 32'h1000_0000 + i);

      // Reset held for two edges with all channels requesting.
      for (int c = 0; c < 2; c++) begin
         next();
         samp();
         check("rst_in_ready",  32'(in_ready),  32'h0);
         check("rst_out_valid", 32'(out_valid), 32'h0);
         check("rst_out_data",  out_data,       32'h0);
      end

      // Single requester on channel 2.
      next();
      rst      = 1'b0;
      in_valid = 4'b0100;
      set_data(2, 32'hAAAA_0004);
      samp();
      check("single_in_ready",  32'(in_ready),  32'h4);
      check("single_pre_valid", 32'(out_valid), 32'h0);
      next();
      in_valid = 4'b0000;
      samp();
      check("single_out_valid", 32'(out_valid), 32'h1);
      check("single_out_data",  out_data,       32'hAAAA_0004);
      check("single_out_idx",   32'(out_idx),   32'h2);

      // Mid-operation reset: no in_ready while rst is high, entry discarded.
      next();
      rst      = 1'b1;
      in_valid = 4'b1111;
      samp();
      check("midrst_in_ready", 32'(in_ready), 32'h0);
      next();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_data(i, 32'hF000_0000 + i);

      // Fairness: all channels valid, out_ready high -> 0,1,2,3,0.
      for (int k = 0; k < 5; k++) begin
         samp();
         check("fair_in_ready", 32'(in_ready), 32'(1 << (k % 4)));
         if (k == 0) begin
            check("fair_first_valid", 32'(out_valid), 32'h0);
         end else begin
            check("fair_out_valid", 32'(out_valid), 32'h1);
            check("fair_out_idx",   32'(out_idx),   32'((k - 1) % 4));
            check("fair_out_data",  out_data,       32'hF000_0000 + 32'((k - 1) % 4));
         end
         next();
      end

      // Backpressure: FULL holding ch0, only ch1 requests, out_ready low.
      in_valid  = 4'b0010;
      out_ready = 1'b0;
      samp();
      check("bp_out_idx", 32'(out_idx), 32'h0);
      for (int j = 0; j < 5; j++) begin
         check("bp_in_ready",  32'(in_ready),  32'h0);
         check("bp_out_data",  out_data,       32'hF000_0000);
         check("bp_out_valid", 32'(out_valid), 32'h1);
         next();
         samp();
      end
      next();
      out_ready = 1'b1;
      samp();
      check("bp_release_in_ready", 32'(in_ready), 32'h2);

      // Load E3A00000 via ch0 (pointer at 2 wraps round to 0).
      next();
      in_valid = 4'b0001;
      set_data(0, 32'hE3A0_0000);
      samp();
      check("bp_next_data",  out_data,       32'hF000_0001);
      check("bp_next_idx",   32'(out_idx),   32'h1);
      check("en_load_ready", 32'(in_ready),  32'h1);
      next();
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      samp();
      check("en_full_data", out_data, 32'hE3A0_0000);

      // Enable masking: outputs forced to 0, state frozen despite out_ready.
      next();
      enable    = 1'b0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      samp();
      check("dis_out_valid", 32'(out_valid), 32'h0);
      check("dis_out_data",  out_data,       32'h0);
      check("dis_out_idx",   32'(out_idx),   32'h0);
      check("dis_in_ready",  32'(in_ready),  32'h0);
      next();
      samp();
      check("dis2_out_valid", 32'(out_valid), 32'h0);
      next();
      enable    = 1'b1;
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      samp();
      check("reen_out_valid", 32'(out_valid), 32'h1);
      check("reen_out_data",  out_data,       32'hE3A0_0000);
      check("reen_out_idx",   32'(out_idx),   32'h0);
      next();
      out_ready = 1'b1;
      samp();
      check("drain_pre_valid", 32'(out_valid), 32'h1);
      next();
      samp();
      check("drain_out_valid", 32'(out_valid), 32'h0);

`ifdef MUX_RR_ARB_LOCK_EN
      // Lock: grant ch0, then hold lock with all channels requesting.
      next();
      rst = 1'b1;
      next();
      rst      = 1'b0;
      in_valid = 4'b0001;
      samp();
      check("lock_first_ready", 32'(in_ready), 32'h1);
      next();
      lock     = 1'b1;
      in_valid = 4'b1111;
      for (int j = 0; j < 3; j++) begin
         samp();
         check("lock_in_ready", 32'(in_ready), 32'h1);
         next();
      end
      lock = 1'b0;
      samp();
      check("lock_out_idx",     32'(out_idx),  32'h0);
      check("unlock_in_ready",  32'(in_ready), 32'h2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule : tb_mux_rr_arb

// File: doc/mux_rr_arb.md
MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 Parameter N, default 32, data width in bits per channel.
REQ-002 Parameter M, default 4, number of input channels; legal range 2..16.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  block enable; when 0, no transfer occurs and outputs are masked.
REQ-006 in_valid  input  M  per-channel request valid.
REQ-007 in_data  input  M*N  flattened channel data; channel i occupies bits [i*N+N-1 : i*N].
REQ-008 in_ready  output  M  per-channel accept; one-hot or zero.
REQ-009 out_valid  output  1  output register holds valid data.
REQ-010 out_data  output  N  registered selected data.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_idx  output  $clog2(M)  channel index of the data in out_data.

Function
REQ-013 The output stage is a 2-state FSM: EMPTY, meaning no valid data, and FULL, meaning data held.
REQ-014 An accept occurs in a cycle when enable=1, some in_valid bit is 1, and the state is EMPTY or out_ready=1.
REQ-015 On an accept, exactly one channel is granted, in_ready of that channel is 1 for that cycle, and its data and index load into out_data/out_idx at the next edge.
REQ-016 Latency from accept to out_valid=1 is 1 cycle; back-to-back accepts with out_ready held at 1 give one transfer per cycle.
REQ-017 Grant order is round-robin: the search starts at pointer ptr and wraps from M-1 to 0; the first valid channel found wins.
REQ-018 After each accept, ptr becomes (granted index + 1) mod M; without an accept, ptr holds.
REQ-019 FSM transitions:
  - EMPTY to FULL on accept.
  - FULL to EMPTY when out_ready=1 and there is no accept.
  - FULL stays FULL when out_ready=0, or when out_ready=1 together with an accept.
REQ-020 When FULL, out_ready=0 and enable=1, all in_ready bits are 0 and out_data/out_idx hold their value.
REQ-021 in_ready is combinational from in_valid, ptr, state, out_ready and enable; no in_ready bit depends on in_data.
REQ-022 When enable=0, the following apply:
  - in_ready=0.
  - out_valid=0.
  - out_data=0.
  - out_idx=0.
  - Internal state and ptr are frozen and the held entry is retained.
  - When enable returns to 1, the held entry is presented again unchanged.
REQ-023 A channel that is granted does not need to deassert in_valid; holding it asserted re-requests in a later round.

Reset
REQ-024 When rst=1 at a rising edge, the following take effect: state=EMPTY, ptr=0, out_data=0, out_idx=0, out_valid=0; rst overrides enable and any accept in the same cycle.
REQ-025 If rst is asserted mid-operation, it discards the held entry; no in_ready is asserted in a cycle in which rst=1.

Configuration
REQ-026 Macro MUX_RR_ARB_LOCK_EN, when defined, adds port lock (input, 1 bit).
REQ-027 With MUX_RR_ARB_LOCK_EN defined and lock=1:
  - Only channel ptr-1 (mod M), the last granted channel, is eligible for a grant.
  - ptr does not advance.
  - When lock=0, normal round-robin behaviour applies.
REQ-028 Without MUX_RR_ARB_LOCK_EN, the lock port is absent and the behaviour is as specified in REQ-017/018.

Structure
REQ-029 Package mux_pkg holds:
  - Default constants MUX_N=32 and MUX_M=4.
  - The FSM state typedef mux_state_t with values EMPTY and FULL.
REQ-030 One sub-module, rr_pick, is a combinational round-robin priority picker with ports req[M], ptr, gnt one-hot [M] and gnt_idx.

Verification
REQ-031 Reset check: rst=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0 throughout.
REQ-032 Single requester: enable=1, out_ready=1, in_valid=4'b0100, ch2 data=32'hAAAA0004 -> in_ready=4'b0100, then on the next cycle out_valid=1, out_data=32'hAAAA0004, out_idx=2.
REQ-033 Fairness: all four channels valid continuously with out_ready=1 -> grant sequence 0,1,2,3,0, one transfer per cycle.
REQ-034 Backpressure: out_ready=0 while FULL and ch1 valid -> in_ready=0 and out_data stable for 5 cycles; on release, ch1 is granted in the same cycle that the held data is consumed.
REQ-035 Enable masking: FULL holding 32'hE3A00000, then enable=0 -> out_valid=0 and out_data=0; after enable=1 -> out_data=32'hE3A00000 again with no loss.
REQ-036 Lock, with MUX_RR_ARB_LOCK_EN defined: ch0 is granted, then lock=1 with in_valid=4'b1111 -> ch0 is granted for 3 consecutive cycles; after lock=0 the next grant is ch1.
